// File: rtl/sseg_scan_ctrl.sv
// Scan scheduler for a 4-digit seven-segment display sharing one BCD decoder.
// Alternates a blanked guard dwell and a per-digit show dwell; new values commit at frame start.
module sseg_scan_ctrl #(
   parameter int unsigned CLK_DIV = 50000,
   parameter int unsigned GUARD   = 64,
   parameter int unsigned CW      = 16
) (
   input  logic        G_CLOCK_50,
   input  logic        rst,
   input  logic [15:0] num_in,
   input  logic        load,
   input  logic        lz_en,
   output logic        load_ack,
   output logic [3:0]  bcd_out,
   output logic [3:0]  an_out,
   output logic        blank_out,
   output logic [1:0]  digit_idx,
   output logic        frame_done
);

   typedef enum logic {StBlank, StShow} state_e;

   state_e        r_state, w_state_d;
   logic [CW-1:0] r_cnt, w_cnt_d;
   logic [1:0]    r_idx, w_idx_d;
   logic          r_first, w_first_d;
   logic [15:0]   r_shadow, w_shadow_d;
   logic [15:0]   r_pending, w_pending_d;
   logic          r_pend_v, w_pend_v_d;
   logic [3:0]    r_bcd, w_bcd_d;
   logic [3:0]    r_an, w_an_d;
   logic          r_blank, w_blank_d;
   logic          r_ack, w_ack_d;
   logic          r_fd, w_fd_d;

   logic          w_blank_end;
   logic          w_show_end;
   logic [1:0]    w_nidx;
   logic          w_commit;
   logic [15:0]   w_new_shadow;
   logic [15:0]   w_upper;
   logic          w_supp;

   assign w_blank_end  = (r_state == StBlank) && (r_cnt == CW'(GUARD - 1));
   assign w_show_end   = (r_state == StShow) && (r_cnt == CW'(CLK_DIV - 1));
   // First guard after reset leads into digit 0 rather than advancing past it.
   assign w_nidx       = r_first ? 2'd0 : r_idx + 2'd1;
   assign w_commit     = w_blank_end && (w_nidx == 2'd0) && (r_pend_v || load);
   // A load coinciding with the commit edge bypasses the pending register.
   assign w_new_shadow = w_commit ? (load ? num_in : r_pending) : r_shadow;
   assign w_upper      = w_new_shadow >> {w_nidx, 2'b00};
   assign w_supp       = lz_en && (w_nidx != 2'd0) && (w_upper == 16'h0000);

   always_ff @(posedge G_CLOCK_50 or posedge rst) begin
      if (rst) begin
         r_state   <= StBlank;
         r_cnt     <= '0;
         r_idx     <= 2'd0;
         r_first   <= 1'b1;
         r_shadow  <= 16'h0000;
         r_pending <= 16'h0000;
         r_pend_v  <= 1'b0;
         r_bcd     <= 4'h0;
         r_an      <= 4'b1111;
         r_blank   <= 1'b1;
         r_ack     <= 1'b0;
         r_fd      <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_cnt     <= w_cnt_d;
         r_idx     <= w_idx_d;
         r_first   <= w_first_d;
         r_shadow  <= w_shadow_d;
         r_pending <= w_pending_d;
         r_pend_v  <= w_pend_v_d;
         r_bcd     <= w_bcd_d;
         r_an      <= w_an_d;
         r_blank   <= w_blank_d;
         r_ack     <= w_ack_d;
         r_fd      <= w_fd_d;
      end
   end

   always_comb begin
      w_state_d   = r_state;
      w_cnt_d     = r_cnt + CW'(1);
      w_idx_d     = r_idx;
      w_first_d   = r_first;
      w_shadow_d  = r_shadow;
      w_pending_d = r_pending;
      w_pend_v_d  = r_pend_v;
      w_bcd_d     = r_bcd;
      w_an_d      = r_an;
      w_blank_d   = r_blank;
      w_ack_d     = 1'b0;
      w_fd_d      = 1'b0;

      if (w_commit) begin
         w_shadow_d = w_new_shadow;
         w_pend_v_d = 1'b0;
         w_ack_d    = 1'b1;
      end else if (load) begin
         w_pending_d = num_in;
         w_pend_v_d  = 1'b1;
      end

      unique case (r_state)
         StBlank: begin
            if (w_blank_end) begin
               w_state_d = StShow;
               w_cnt_d   = '0;
               w_idx_d   = w_nidx;
               w_first_d = 1'b0;
               w_bcd_d   = w_new_shadow[{w_nidx, 2'b00} +: 4];
               w_an_d    = w_supp ? 4'b1111 : ~(4'b0001 << w_nidx);
               w_blank_d = w_supp;
            end
         end
         StShow: begin
            if (w_show_end) begin
               w_state_d = StBlank;
               w_cnt_d   = '0;
               w_an_d    = 4'b1111;
               w_blank_d = 1'b1;
               w_fd_d    = (r_idx == 2'd3);
            end
         end
         default: begin
            w_state_d = StBlank;
            w_cnt_d   = '0;
         end
      endcase
   end

   assign load_ack   = r_ack;
   assign bcd_out    = r_bcd;
   assign an_out     = r_an;
   assign blank_out  = r_blank;
   assign digit_idx  = r_idx;
   assign frame_done = r_fd;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl with CLK_DIV=4, GUARD=2 (digit period 6, frame 24).
module tb_sseg_scan_ctrl;

   logic        clk;
   logic        rst;
   logic [15:0] num_in;
   logic        load;
   logic        lz_en;
   logic        load_ack;
   logic [3:0]  bcd_out;
   logic [3:0]  an_out;
   logic        blank_out;
   logic [1:0]  digit_idx;
   logic        frame_done;

   int n_vec;
   int n_err;

   sseg_scan_ctrl #(
      .CLK_DIV (4),
      .GUARD   (2),
      .CW      (16)
   ) dut (
      .G_CLOCK_50 (clk),
      .rst        (rst),
      .num_in     (num_in),
      .load       (load),
      .lz_en      (lz_en),
      .load_ack   (load_ack),
      .bcd_out    (bcd_out),
      .an_out     (an_out),
      .blank_out  (blank_out),
      .digit_idx  (digit_idx),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Caller is positioned on the negedge of frame phase 0; returns on the next frame's phase 0
   // (or after nsamp phases). Loads are driven just after the sample at phases la1/la2.
   task automatic run_frame(input int fr, input logic [15:0] val, input logic ack_exp,
                            input logic fd_exp, input int nsamp,
                            input int la1, input logic [15:0] lv1,
                            input int la2, input logic [15:0] lv2);
      for (int p = 0; p < nsamp; p++) begin
         int   d;
         logic show;
         logic supp;
         logic [3:0] exp_an;
         d      = p / 6;
         show   = (p % 6) >= 2;
         supp   = lz_en && (d != 0) && ((val >> (4 * d)) == 16'h0);
         exp_an = (show && !supp) ? ~(4'b0001 << d) : 4'b1111;
         check_eq($sformatf("f%0d p%0d an_out", fr, p), {12'h0, an_out}, {12'h0, exp_an});
         check_eq($sformatf("f%0d p%0d blank_out", fr, p), {15'h0, blank_out},
                  {15'h0, !(show && !supp)});
         check_eq($sformatf("f%0d p%0d load_ack", fr, p), {15'h0, load_ack},
                  {15'h0, (p == 2) && ack_exp});
         check_eq($sformatf("f%0d p%0d frame_done", fr, p), {15'h0, frame_done},
                  {15'h0, (p == 0) && fd_exp});
         if (show) begin
            check_eq($sformatf("f%0d p%0d bcd_out", fr, p), {12'h0, bcd_out},
                     {12'h0, 4'((val >> (4 * d)) & 16'hF)});
            check_eq($sformatf("f%0d p%0d digit_idx", fr, p), {14'h0, digit_idx}, 16'(d));
         end
         load   = (p == la1) || (p == la2);
         num_in = (p == la2) ? lv2 : lv1;
         @(negedge clk);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, " an_out"},     {12'h0, an_out},     16'h000F);
      check_eq({tag, " blank_out"},  {15'h0, blank_out},  16'h0001);
      check_eq({tag, " bcd_out"},    {12'h0, bcd_out},    16'h0000);
      check_eq({tag, " digit_idx"},  {14'h0, digit_idx},  16'h0000);
      check_eq({tag, " load_ack"},   {15'h0, load_ack},   16'h0000);
      check_eq({tag, " frame_done"}, {15'h0, frame_done}, 16'h0000);
   endtask

   initial begin
      n_vec  = 0;
      n_err  = 0;
      rst    = 1'b1;
      load   = 1'b0;
      lz_en  = 1'b0;
      num_in = 16'h0000;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;

      // Blank scan, then 1234 loaded mid-frame shows from the next frame.
      run_frame(0, 16'h0000, 1'b0, 1'b0, 24, 10, 16'h1234, -1, 16'h0);
      run_frame(1, 16'h1234, 1'b1, 1'b1, 24, -1, 16'h0, -1, 16'h0);
      // Two loads before the boundary: last wins, single ack.
      run_frame(2, 16'h1234, 1'b0, 1'b1, 24, 5, 16'h1111, 15, 16'h5678);
      run_frame(3, 16'h5678, 1'b1, 1'b1, 24, -1, 16'h0, -1, 16'h0);
      // Load on the exact commit edge.
      run_frame(4, 16'h9ABC, 1'b1, 1'b1, 24, 1, 16'h9ABC, -1, 16'h0);
      run_frame(5, 16'h9ABC, 1'b0, 1'b1, 24, -1, 16'h0, -1, 16'h0);
      // Leading-zero suppression.
      lz_en = 1'b1;
      run_frame(6, 16'h0007, 1'b1, 1'b1, 24, 1, 16'h0007, -1, 16'h0);
      run_frame(7, 16'h0000, 1'b1, 1'b1, 24, 1, 16'h0000, -1, 16'h0);
      run_frame(8, 16'h0120, 1'b1, 1'b1, 24, 1, 16'h0120, -1, 16'h0);
      lz_en = 1'b0;
      // Pending load, then reset while showing digit 2.
      run_frame(9, 16'h0120, 1'b0, 1'b1, 15, 3, 16'h4321, -1, 16'h0);
      #1 rst = 1'b1;
      load = 1'b0;
      #1 check_reset_outputs("async_rst");
      @(negedge clk);
      rst = 1'b0;
      run_frame(10, 16'h0000, 1'b0, 1'b0, 24, -1, 16'h0, -1, 16'h0);
      run_frame(11, 16'h0000, 1'b0, 1'b1, 24, -1, 16'h0, -1, 16'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
